// File: rtl/data_fifo_wr_if.sv
// Stream bundle carrying one write-data beat: payload plus tvalid/tready handshake.
// Latency: none, wires only.
// Backpressure: the master holds a beat until the slave raises tready.
interface data_fifo_wr_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      tvalid;
  logic                      tready;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [DATA_WIDTH/8-1:0]   tkeep;
  logic                      tlast;
  logic [15:0]               tid;
  logic [3:0]                tuser;

  modport master (
    output tvalid, tdata, tkeep, tlast, tid, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast, tid, tuser,
    output tready
  );
endinterface

// File: rtl/data_fifo_wr.sv
// Write-data FIFO with first-word-fall-through output register and optional store-and-forward gating.
// Latency: a beat pushed on edge k into an empty FIFO is presented on m_axis after edge k+1 (cut-through).
// Backpressure: s_axis_tready drops at DEPTH stored beats, s_fifo_ready at PROG_FULL_THRESH; m_axis stalls hold the output register.
module data_fifo_wr #(
  parameter int DATA_WIDTH       = 32,
  parameter int DEPTH            = 512,
  parameter int PROG_FULL_THRESH = 448,
  parameter int PKT_MODE         = 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  data_fifo_wr_if.slave            s_axis,
  data_fifo_wr_if.master           m_axis,
  output logic                     s_fifo_ready,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic [15:0]              pkt_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          KW        = DATA_WIDTH / 8;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C  = (AW+1)'(PROG_FULL_THRESH);
  localparam bit          STORE_FWD = (PKT_MODE != 0);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KW-1:0]         keep;
    logic                  last;
    logic [15:0]           id;
    logic [3:0]            user;
  } beat_t;

  // STORE: release beats only once a whole packet is held.
  // CUT:   an oversize packet filled the FIFO, so stream it out until its tlast leaves.
  typedef enum logic {
    ST_STORE = 1'b0,
    ST_CUT   = 1'b1
  } state_t;

  beat_t       mem [DEPTH];
  beat_t       in_beat;
  beat_t       out_beat;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] cnt_q;
  logic [15:0] pkt_q;
  logic        out_vld;
  logic        run_q;
  logic        push;
  logic        pop;
  logic        wr_en;
  logic        mem_empty;
  logic        mem_full;
  logic        load_out;
  logic        push_last;
  logic        pop_last;
  logic        pkt_gate;
  state_t      state_q;
  state_t      state_d;

  assign in_beat = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tid, s_axis.tuser};

  // Ready flags come straight from the registered count so the input path has no
  // combinational dependency on m_axis_tready; a full FIFO refuses even on a pop edge.
  assign s_axis.tready = run_q && (cnt_q < DEPTH_C);
  assign s_fifo_ready  = run_q && (cnt_q < THRESH_C);

  assign push      = s_axis.tvalid && s_axis.tready;
  assign pkt_gate  = !STORE_FWD || (state_q == ST_CUT) || (pkt_q != 16'd0);
  assign pop       = m_axis.tvalid && m_axis.tready;
  assign push_last = push && s_axis.tlast;
  assign pop_last  = pop && out_beat.last;

  // The extra pointer MSB separates a wrapped (full) array from an empty one.
  assign mem_empty = (wr_ptr == rd_ptr);
  assign mem_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en     = push && !mem_full;

  // Refill the output register whenever it is free or being drained this cycle.
  assign load_out  = !mem_empty && (!out_vld || pop);

  assign m_axis.tvalid = out_vld && pkt_gate;
  assign m_axis.tdata  = out_beat.data;
  assign m_axis.tkeep  = out_beat.keep;
  assign m_axis.tlast  = out_beat.last;
  assign m_axis.tid    = out_beat.id;
  assign m_axis.tuser  = out_beat.user;

  assign data_count = cnt_q;
  assign pkt_count  = pkt_q;

  // Hold the input side off until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Storage array: payload only, never reset; validity is tracked by the pointers.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_beat;
    end
  end

  // Write pointer advances on every accepted beat, wrapping modulo 2*DEPTH.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Output register and read pointer: first-word-fall-through from the array.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr   <= '0;
      out_vld  <= 1'b0;
      out_beat <= '0;
    end else if (load_out) begin
      rd_ptr   <= rd_ptr + 1'b1;
      out_vld  <= 1'b1;
      out_beat <= mem[rd_ptr[AW-1:0]];
    end else if (pop) begin
      out_vld  <= 1'b0;
    end
  end

  // Stored-beat count, including the beat sitting in the output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Complete-packet count: a tlast in and a tlast out on the same edge cancel.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_q <= 16'd0;
    end else if (push_last && !pop_last) begin
      if (pkt_q != 16'hFFFF) begin
        pkt_q <= pkt_q + 16'd1;
      end
    end else if (pop_last && !push_last) begin
      if (pkt_q != 16'd0) begin
        pkt_q <= pkt_q - 16'd1;
      end
    end
  end

  // Mode state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_STORE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a full FIFO with no complete packet can never drain in STORE,
  // so switch to CUT; return once the oversize packet's tlast has left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STORE: begin
        if (STORE_FWD && (cnt_q == DEPTH_C) && (pkt_q == 16'd0)) begin
          state_d = ST_CUT;
        end
      end
      ST_CUT: begin
        if (pop_last) begin
          state_d = ST_STORE;
        end
      end
      default: state_d = ST_STORE;
    endcase
  end

endmodule

// File: tb/tb_data_fifo_wr.sv
module tb_data_fifo_wr;
  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int THR   = 448;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [15:0] id;
    logic [3:0]  user;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  data_fifo_wr_if #(.DATA_WIDTH(DW)) sf_s ();
  data_fifo_wr_if #(.DATA_WIDTH(DW)) sf_m ();
  data_fifo_wr_if #(.DATA_WIDTH(DW)) ct_s ();
  data_fifo_wr_if #(.DATA_WIDTH(DW)) ct_m ();

  logic        sf_fifo_rdy, ct_fifo_rdy;
  logic [9:0]  sf_cnt, ct_cnt;
  logic [15:0] sf_pk, ct_pk;

  data_fifo_wr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PROG_FULL_THRESH(THR), .PKT_MODE(1)) u_sf (
    .aclk(aclk), .aresetn(aresetn), .s_axis(sf_s), .m_axis(sf_m),
    .s_fifo_ready(sf_fifo_rdy), .data_count(sf_cnt), .pkt_count(sf_pk));

  data_fifo_wr #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PROG_FULL_THRESH(THR), .PKT_MODE(0)) u_ct (
    .aclk(aclk), .aresetn(aresetn), .s_axis(ct_s), .m_axis(ct_m),
    .s_fifo_ready(ct_fifo_rdy), .data_count(ct_cnt), .pkt_count(ct_pk));

  // Shared stimulus routed to the selected instance.
  logic  use_ct;
  logic  drv_vld;
  logic  drv_mrdy;
  beat_t drv_beat;

  assign sf_s.tvalid = drv_vld & ~use_ct;
  assign ct_s.tvalid = drv_vld & use_ct;
  assign sf_s.tdata  = drv_beat.data;  assign ct_s.tdata  = drv_beat.data;
  assign sf_s.tkeep  = drv_beat.keep;  assign ct_s.tkeep  = drv_beat.keep;
  assign sf_s.tlast  = drv_beat.last;  assign ct_s.tlast  = drv_beat.last;
  assign sf_s.tid    = drv_beat.id;    assign ct_s.tid    = drv_beat.id;
  assign sf_s.tuser  = drv_beat.user;  assign ct_s.tuser  = drv_beat.user;
  assign sf_m.tready = drv_mrdy & ~use_ct;
  assign ct_m.tready = drv_mrdy & use_ct;

  logic        o_tready, o_fifo_rdy, o_mvld;
  beat_t       o_beat;
  logic [9:0]  o_cnt;
  logic [15:0] o_pk;

  always_comb begin
    if (use_ct) begin
      o_tready = ct_s.tready; o_fifo_rdy = ct_fifo_rdy; o_mvld = ct_m.tvalid;
      o_beat = {ct_m.tdata, ct_m.tkeep, ct_m.tlast, ct_m.tid, ct_m.tuser};
      o_cnt = ct_cnt; o_pk = ct_pk;
    end else begin
      o_tready = sf_s.tready; o_fifo_rdy = sf_fifo_rdy; o_mvld = sf_m.tvalid;
      o_beat = {sf_m.tdata, sf_m.tkeep, sf_m.tlast, sf_m.tid, sf_m.tuser};
      o_cnt = sf_cnt; o_pk = sf_pk;
    end
  end

  // Reference model: ordered beat queue and complete-packet counter.
  beat_t q[$];
  int    pk;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic beat_t mk(input int i, input bit last, input logic [15:0] id);
    beat_t b;
    b.data = 32'(i);
    b.keep = 4'(i);
    b.last = last;
    b.id   = id;
    b.user = 4'(i >> 3);
    return b;
  endfunction

  // One clock: sample handshakes mid-cycle, update the model, return after the edge.
  task automatic step(output bit pushed, output bit popped, output bit stalled,
                      output beat_t got, output beat_t exp_b);
    beat_t in_b;
    @(negedge aclk);
    in_b    = drv_beat;
    pushed  = drv_vld && o_tready;
    popped  = o_mvld && drv_mrdy;
    stalled = o_mvld && !drv_mrdy;
    got     = o_beat;
    exp_b   = ~o_beat;
    if (popped && q.size() > 0) exp_b = q.pop_front();
    if (pushed) q.push_back(in_b);
    if (pushed && in_b.last && !(popped && exp_b.last)) begin
      if (pk < 65535) pk++;
    end else if (popped && exp_b.last && !(pushed && in_b.last)) begin
      if (pk > 0) pk--;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    aresetn = 1'b0; drv_vld = 1'b0; drv_mrdy = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      use_ct = (k == 1);
      #1;
      n_tests++; if (o_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready[%0d]: got %b expected 0", k, o_tready); end
      n_tests++; if (o_fifo_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_ready[%0d]: got %b expected 0", k, o_fifo_rdy); end
      n_tests++; if (o_mvld !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid[%0d]: got %b expected 0", k, o_mvld); end
      n_tests++; if (o_beat !== '0) begin n_fail++; $display("FAIL rst_payload[%0d]: got %h expected 0", k, o_beat); end
      n_tests++; if (o_cnt !== 10'd0) begin n_fail++; $display("FAIL rst_count[%0d]: got %0d expected 0", k, o_cnt); end
      n_tests++; if (o_pk !== 16'd0) begin n_fail++; $display("FAIL rst_pkt[%0d]: got %0d expected 0", k, o_pk); end
    end
    use_ct = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    #1;
    n_tests++; if (o_tready !== 1'b0) begin n_fail++; $display("FAIL rel_tready_early: got %b expected 0", o_tready); end
    @(posedge aclk); #1;
    n_tests++; if (o_tready !== 1'b1) begin n_fail++; $display("FAIL rel_tready: got %b expected 1", o_tready); end
    n_tests++; if (o_fifo_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_fifo_ready: got %b expected 1", o_fifo_rdy); end
    q.delete(); pk = 0;
  endtask

  task automatic test_store_fwd;
    bit pu, po, st; beat_t g, e; int sent = 0; int rcv = 0;
    use_ct = 1'b0; drv_mrdy = 1'b1;
    for (int c = 0; c < 30; c++) begin
      drv_vld  = (sent < 4);
      drv_beat = mk(sent, sent == 3, 16'h0005);
      step(pu, po, st, g, e);
      if (pu) sent++;
      if (po) begin
        rcv++;
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL sf_data: got %h expected %h", g, e); end
      end
      if (sent < 4) begin
        n_tests++; if (o_mvld !== 1'b0) begin n_fail++; $display("FAIL sf_early_valid: got %b expected 0 (sent %0d)", o_mvld, sent); end
      end
      if (pu && sent == 4) begin
        n_tests++; if (o_pk !== 16'd1) begin n_fail++; $display("FAIL sf_pkt_up: got %0d expected 1", o_pk); end
      end
    end
    drv_vld = 1'b0;
    n_tests++; if (rcv != 4) begin n_fail++; $display("FAIL sf_beats: got %0d expected 4", rcv); end
    n_tests++; if (o_pk !== 16'd0) begin n_fail++; $display("FAIL sf_pkt_down: got %0d expected 0", o_pk); end
    n_tests++; if (o_cnt !== 10'd0) begin n_fail++; $display("FAIL sf_empty: got %0d expected 0", o_cnt); end
  endtask

  task automatic test_cut_through;
    bit pu, po, st; beat_t g, e; int sent = 0; int rcv = 0;
    use_ct = 1'b1; drv_mrdy = 1'b1;
    for (int c = 0; c < 1100; c++) begin
      drv_vld  = (sent < 1000);
      drv_beat = mk(sent, (sent % 10) == 9, 16'h0C00);
      step(pu, po, st, g, e);
      if (pu) sent++;
      if (c == 0) begin
        n_tests++; if (o_mvld !== 1'b0) begin n_fail++; $display("FAIL ct_latency0: got %b expected 0", o_mvld); end
      end
      if (c == 1) begin
        n_tests++; if (o_mvld !== 1'b1) begin n_fail++; $display("FAIL ct_latency1: got %b expected 1", o_mvld); end
      end
      if (c >= 2 && c < 1000) begin
        n_tests++; if (!(pu && po)) begin n_fail++; $display("FAIL ct_rate: push %b pop %b expected 1 1 at cycle %0d", pu, po, c); end
        n_tests++; if (o_cnt !== 10'd2) begin n_fail++; $display("FAIL ct_count: got %0d expected 2", o_cnt); end
      end
      if (po) begin
        n_tests++; if (g !== e || g.data !== 32'(rcv)) begin n_fail++; $display("FAIL ct_data: got %h expected %h (index %0d)", g, e, rcv); end
        rcv++;
      end
      n_tests++; if (o_pk !== 16'(pk)) begin n_fail++; $display("FAIL ct_pkt: got %0d expected %0d", o_pk, pk); end
      if (rcv == 1000) break;
    end
    drv_vld = 1'b0;
    n_tests++; if (rcv != 1000) begin n_fail++; $display("FAIL ct_total: got %0d expected 1000", rcv); end
  endtask

  task automatic test_full;
    bit pu, po, st; beat_t g, e; int sent = 0; int rcv = 0;
    use_ct = 1'b1; drv_mrdy = 1'b0;
    for (int c = 0; c < 530; c++) begin
      drv_vld  = 1'b1;
      drv_beat = mk(sent, (sent % 64) == 63, 16'h00F0);
      step(pu, po, st, g, e);
      if (pu) sent++;
      n_tests++; if (o_cnt !== 10'(q.size())) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", o_cnt, q.size()); end
      n_tests++; if (o_fifo_rdy !== (q.size() < THR)) begin n_fail++; $display("FAIL full_prog: got %b at count %0d", o_fifo_rdy, q.size()); end
      n_tests++; if (o_tready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL full_tready: got %b at count %0d", o_tready, q.size()); end
    end
    n_tests++; if (sent != DEPTH) begin n_fail++; $display("FAIL full_accepted: got %0d expected %0d", sent, DEPTH); end
    drv_vld = 1'b0; drv_mrdy = 1'b1;
    for (int c = 0; c < 600; c++) begin
      step(pu, po, st, g, e);
      if (po) begin
        rcv++;
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL full_data: got %h expected %h", g, e); end
      end
      if (q.size() == 0) break;
    end
    n_tests++; if (rcv != DEPTH) begin n_fail++; $display("FAIL full_drain: got %0d expected %0d", rcv, DEPTH); end
    n_tests++; if (o_pk !== 16'd0) begin n_fail++; $display("FAIL full_pkt: got %0d expected 0", o_pk); end
  endtask

  task automatic test_oversize;
    bit pu, po, st; beat_t g, e; int sent = 0; int rcv = 0; bit saw_full = 0;
    use_ct = 1'b0; drv_mrdy = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      drv_vld  = (sent < 600);
      drv_beat = mk(sent, sent == 599, 16'h0600);
      step(pu, po, st, g, e);
      if (pu) sent++;
      if (po) begin
        rcv++;
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL big_data: got %h expected %h", g, e); end
      end
      if (q.size() == DEPTH) saw_full = 1;
      if (!saw_full && pk == 0) begin
        n_tests++; if (o_mvld !== 1'b0) begin n_fail++; $display("FAIL big_early_valid: got %b at count %0d", o_mvld, q.size()); end
      end
      n_tests++; if (o_cnt !== 10'(q.size())) begin n_fail++; $display("FAIL big_count: got %0d expected %0d", o_cnt, q.size()); end
      if (rcv == 600) break;
    end
    drv_vld = 1'b0;
    n_tests++; if (!saw_full) begin n_fail++; $display("FAIL big_reached_full: got 0 expected 1"); end
    n_tests++; if (rcv != 600) begin n_fail++; $display("FAIL big_total: got %0d expected 600", rcv); end
    sent = 0; rcv = 0;
    for (int c = 0; c < 30; c++) begin
      drv_vld  = (sent == 0) || (sent == 1 && c >= 10);
      drv_beat = mk(700 + sent, sent == 1, 16'h0601);
      step(pu, po, st, g, e);
      if (pu) sent++;
      if (po) begin
        rcv++;
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL big_after_data: got %h expected %h", g, e); end
      end
      if (pk == 0 && sent < 2) begin
        n_tests++; if (o_mvld !== 1'b0) begin n_fail++; $display("FAIL big_store_again: got %b expected 0", o_mvld); end
      end
    end
    drv_vld = 1'b0;
    n_tests++; if (rcv != 2) begin n_fail++; $display("FAIL big_after_total: got %0d expected 2", rcv); end
  endtask

  task automatic test_reset_mid;
    bit pu, po, st; beat_t g, e; int sent = 0; int rcv = 0;
    use_ct = 1'b0; drv_mrdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drv_vld  = (sent < 3);
      drv_beat = mk(sent, 1'b0, 16'h0031);
      step(pu, po, st, g, e);
      if (pu) sent++;
      n_tests++; if (o_mvld !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", o_mvld); end
      if (sent == 3) break;
    end
    aresetn = 1'b0; drv_vld = 1'b0;
    #1;
    n_tests++; if (o_tready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tready: got %b expected 0", o_tready); end
    n_tests++; if (o_fifo_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_prog: got %b expected 0", o_fifo_rdy); end
    n_tests++; if (o_mvld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mvalid: got %b expected 0", o_mvld); end
    n_tests++; if (o_beat !== '0) begin n_fail++; $display("FAIL mid_rst_payload: got %h expected 0", o_beat); end
    n_tests++; if (o_cnt !== 10'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", o_cnt); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    q.delete(); pk = 0;
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      drv_vld  = (sent < 2);
      drv_beat = mk(100 + sent, sent == 1, 16'h0077);
      step(pu, po, st, g, e);
      if (pu) sent++;
      if (po) begin
        rcv++;
        n_tests++; if (g !== e || g.id !== 16'h0077) begin n_fail++; $display("FAIL mid_data: got %h expected %h", g, e); end
      end
    end
    drv_vld = 1'b0;
    n_tests++; if (rcv != 2) begin n_fail++; $display("FAIL mid_total: got %0d expected 2", rcv); end
    n_tests++; if (o_pk !== 16'd0) begin n_fail++; $display("FAIL mid_pkt: got %0d expected 0", o_pk); end
  endtask

  task automatic test_random;
    bit pu, po, st; beat_t g, e; bit sent_last = 0; int coinc = 0;
    use_ct = 1'b0; drv_vld = 1'b0; pu = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!drv_vld || pu) begin
        drv_beat.data = $urandom;
        drv_beat.keep = 4'($urandom);
        drv_beat.last = ($urandom_range(0, 4) == 0);
        drv_beat.id   = 16'($urandom);
        drv_beat.user = 4'($urandom);
        drv_vld       = ($urandom_range(0, 3) != 0);
      end
      drv_mrdy = ($urandom_range(0, 1) == 1);
      step(pu, po, st, g, e);
      if (po) begin
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL rnd_data: got %h expected %h", g, e); end
      end
      if (pu && po && drv_beat.last && e.last) coinc++;
      if (st) begin
        n_tests++; if (o_mvld !== 1'b1 || o_beat !== g) begin n_fail++; $display("FAIL rnd_stall: got %b/%h expected 1/%h", o_mvld, o_beat, g); end
      end
      n_tests++; if (o_pk !== 16'(pk)) begin n_fail++; $display("FAIL rnd_pkt: got %0d expected %0d", o_pk, pk); end
      n_tests++; if (o_cnt !== 10'(q.size())) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", o_cnt, q.size()); end
    end
    $display("[TB] random phase coincident tlast edges: %0d", coinc);
    drv_mrdy = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      drv_vld       = !sent_last;
      drv_beat.last = 1'b1;
      step(pu, po, st, g, e);
      if (pu) sent_last = 1;
      if (po) begin
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL rnd_drain_data: got %h expected %h", g, e); end
      end
      if (sent_last && q.size() == 0) break;
    end
    drv_vld = 1'b0;
    n_tests++; if (q.size() != 0 || o_cnt !== 10'd0) begin n_fail++; $display("FAIL rnd_drained: got %0d expected 0", o_cnt); end
    n_tests++; if (o_pk !== 16'd0) begin n_fail++; $display("FAIL rnd_pkt_end: got %0d expected 0", o_pk); end
  endtask

  initial begin
    aresetn  = 1'b0;
    use_ct   = 1'b0;
    drv_vld  = 1'b0;
    drv_mrdy = 1'b0;
    drv_beat = '0;
    pk       = 0;
    test_reset();
    test_store_fwd();
    test_cut_through();
    test_full();
    test_oversize();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
